// File: rtl/vga_pkg.sv
// Shared VGA timing defaults (640x480@60), total-count helpers and the RGB pixel type.
package vga_pkg;

  localparam int DEF_COLOR_BITS = 24;
  localparam int CH_BITS        = DEF_COLOR_BITS / 3;

  localparam int DEF_H_ACTIVE   = 640;
  localparam int DEF_H_FP       = 16;
  localparam int DEF_H_SYNC     = 96;
  localparam int DEF_H_BP       = 48;
  localparam int DEF_V_ACTIVE   = 480;
  localparam int DEF_V_FP       = 10;
  localparam int DEF_V_SYNC     = 2;
  localparam int DEF_V_BP       = 33;
  localparam int DEF_PIPE_DELAY = 2;

  typedef struct packed {
    logic [CH_BITS-1:0] red;
    logic [CH_BITS-1:0] green;
    logic [CH_BITS-1:0] blue;
  } rgb_t;

  function automatic int h_total(input int act, input int fp, input int sync, input int bp);
    return act + fp + sync + bp;
  endfunction

  function automatic int v_total(input int act, input int fp, input int sync, input int bp);
    return act + fp + sync + bp;
  endfunction

endpackage

// File: rtl/vga_delay_line.sv
// WIDTH x DEPTH shift register, async active-low clear; DEPTH = 0 is a wire.
module vga_delay_line #(
  parameter int WIDTH = 1,
  parameter int DEPTH = 1
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic [WIDTH-1:0] i_d,
  output logic [WIDTH-1:0] o_q
);

  if (DEPTH == 0) begin : g_pass
    logic w_unused;
    assign w_unused = i_clk ^ i_rst_n;
    assign o_q      = i_d;
  end else begin : g_sr
    logic [DEPTH-1:0][WIDTH-1:0] r_sr;

    // shift one stage per clock; never stalls so the pins always drain
    always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
        r_sr <= '0;
      end else begin
        r_sr[0] <= i_d;
        for (int i = 1; i < DEPTH; i++) r_sr[i] <= r_sr[i-1];
      end
    end

    assign o_q = r_sr[DEPTH-1];
  end

endmodule

// File: rtl/vga_timing_gen.sv
// VGA raster timing: counters, renderer strobes, and pin-aligned sync/blank/colour.
// Define VGA_TEST_PATTERN_EN to replace the colour input with 8 vertical colour bars.
module vga_timing_gen
  import vga_pkg::*;
#(
  parameter int COLOR_BITS      = DEF_COLOR_BITS,
  parameter int H_ACTIVE        = DEF_H_ACTIVE,
  parameter int H_FP            = DEF_H_FP,
  parameter int H_SYNC          = DEF_H_SYNC,
  parameter int H_BP            = DEF_H_BP,
  parameter int V_ACTIVE        = DEF_V_ACTIVE,
  parameter int V_FP            = DEF_V_FP,
  parameter int V_SYNC          = DEF_V_SYNC,
  parameter int V_BP            = DEF_V_BP,
  parameter int SYNC_ACTIVE_LOW = 1,
  parameter int PIPE_DELAY      = DEF_PIPE_DELAY,
  localparam int H_TOTAL = h_total(H_ACTIVE, H_FP, H_SYNC, H_BP),
  localparam int V_TOTAL = v_total(V_ACTIVE, V_FP, V_SYNC, V_BP),
  localparam int HW      = $clog2(H_TOTAL),
  localparam int VW      = $clog2(V_TOTAL),
  localparam int CW      = COLOR_BITS / 3
) (
  input  logic          clk_i,
  input  logic          rst_ni,
  input  logic          enable_i,
  output logic [HW-1:0] x_o,
  output logic [VW-1:0] y_o,
  output logic          display_enable_o,
  output logic          line_start_o,
  output logic          frame_start_o,
  input  logic [CW-1:0] red_i,
  input  logic [CW-1:0] green_i,
  input  logic [CW-1:0] blue_i,
  output logic          hsync_o,
  output logic          vsync_o,
  output logic          blank_n_o,
  output logic [CW-1:0] red_o,
  output logic [CW-1:0] green_o,
  output logic [CW-1:0] blue_o
);

  typedef struct packed {
    logic [CW-1:0] red;
    logic [CW-1:0] green;
    logic [CW-1:0] blue;
  } pix_t;

  // pin level when sync is not asserted
  localparam logic SYNC_IDLE = (SYNC_ACTIVE_LOW != 0);

  logic [HW-1:0] r_h;
  logic [VW-1:0] r_v;
  logic          w_h_last, w_v_last;
  logic          w_hs_raw, w_vs_raw, w_de_raw;
  logic [2:0]    w_raw, w_raw_d;
  pix_t          w_src;
  pix_t          r_rgb;
  logic          r_hsync, r_vsync, r_blank_n;

  assign w_h_last = (r_h == HW'(H_TOTAL - 1));
  assign w_v_last = (r_v == VW'(V_TOTAL - 1));

  // raster counters; enable low parks them at the origin
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_h <= '0;
      r_v <= '0;
    end else if (!enable_i) begin
      r_h <= '0;
      r_v <= '0;
    end else if (w_h_last) begin
      r_h <= '0;
      r_v <= w_v_last ? '0 : r_v + VW'(1);
    end else begin
      r_h <= r_h + HW'(1);
    end
  end

  // raw decode, active-high, all gated by enable so the pipe drains when stopped
  assign w_hs_raw = enable_i && (r_h >= HW'(H_ACTIVE + H_FP))
                             && (r_h <  HW'(H_ACTIVE + H_FP + H_SYNC));
  assign w_vs_raw = enable_i && (r_v >= VW'(V_ACTIVE + V_FP))
                             && (r_v <  VW'(V_ACTIVE + V_FP + V_SYNC));
  assign w_de_raw = enable_i && (r_h < HW'(H_ACTIVE)) && (r_v < VW'(V_ACTIVE));

  assign x_o              = r_h;
  assign y_o              = r_v;
  assign display_enable_o = w_de_raw;
  assign line_start_o     = enable_i && (r_h == '0);
  assign frame_start_o    = enable_i && (r_h == '0) && (r_v == '0);

  assign w_raw = {w_hs_raw, w_vs_raw, w_de_raw};

  vga_delay_line #(.WIDTH(3), .DEPTH(PIPE_DELAY)) u_sync_dly (
    .i_clk   (clk_i),
    .i_rst_n (rst_ni),
    .i_d     (w_raw),
    .o_q     (w_raw_d)
  );

`ifdef VGA_TEST_PATTERN_EN
  localparam int BAR_W = H_ACTIVE / 8;

  logic [HW-1:0] w_x_d;
  logic [2:0]    w_bar;
  logic          w_unused;

  assign w_unused = ^{red_i, green_i, blue_i};

  vga_delay_line #(.WIDTH(HW), .DEPTH(PIPE_DELAY)) u_x_dly (
    .i_clk   (clk_i),
    .i_rst_n (rst_ni),
    .i_d     (r_h),
    .o_q     (w_x_d)
  );

  // bar index bits map to white,yellow,cyan,green,magenta,red,blue,black
  assign w_bar = 3'(w_x_d / HW'(BAR_W));
  assign w_src = '{red:   {CW{~w_bar[1]}},
                   green: {CW{~w_bar[2]}},
                   blue:  {CW{~w_bar[0]}}};
`else
  assign w_src = '{red: red_i, green: green_i, blue: blue_i};
`endif

  // pin register: delayed sync/blank plus the colour that belongs to the same pixel
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_hsync   <= SYNC_IDLE;
      r_vsync   <= SYNC_IDLE;
      r_blank_n <= 1'b0;
      r_rgb     <= '0;
    end else begin
      r_hsync   <= w_raw_d[2] ? ~SYNC_IDLE : SYNC_IDLE;
      r_vsync   <= w_raw_d[1] ? ~SYNC_IDLE : SYNC_IDLE;
      r_blank_n <= w_raw_d[0];
      r_rgb     <= w_raw_d[0] ? w_src : '0;
    end
  end

  assign hsync_o   = r_hsync;
  assign vsync_o   = r_vsync;
  assign blank_n_o = r_blank_n;
  assign red_o     = r_rgb.red;
  assign green_o   = r_rgb.green;
  assign blue_o    = r_rgb.blue;

endmodule

// File: doc/vga_timing_gen.md
Name: vga_timing_gen

Overview:
- Generates the raster timing that the pixel renderer consumes.
  - Outputs: pixel coordinates, display enable, and line/frame strobes.
- Captures the renderer's RGB colour returned for each pixel.
- Drives the VGA pins (hsync, vsync, blank, colour) with sync and blank delayed to line up with the renderer pipeline.
- Sits between the game/render logic and the DAC/HDMI encoder, in the pixel clock domain.

Parameters:
- COLOR_BITS, 24, total RGB width; each channel is COLOR_BITS/3.
- H_ACTIVE, 640, visible pixels per line.
- H_FP, 16, horizontal front porch in clocks.
- H_SYNC, 96, hsync pulse width in clocks.
- H_BP, 48, horizontal back porch in clocks.
- V_ACTIVE, 480, visible lines per frame.
- V_FP, 10, vertical front porch in lines.
- V_SYNC, 2, vsync pulse width in lines.
- V_BP, 33, vertical back porch in lines.
- SYNC_ACTIVE_LOW, 1, 1 = hsync/vsync pulses are low.
- PIPE_DELAY, 2, clocks from x_o/y_o/display_enable_o to valid red_i/green_i/blue_i; legal range 0..8.

Ports:
- clk_i  in  1  pixel clock.
- rst_ni  in  1  asynchronous active-low reset.
- enable_i  in  1  run raster; low = hold counters at origin.
- x_o  out  10  horizontal counter, 0..H_TOTAL-1.
- y_o  out  10  vertical counter, 0..V_TOTAL-1.
- display_enable_o  out  1  x_o < H_ACTIVE and y_o < V_ACTIVE.
- line_start_o  out  1  one-clock strobe at x_o==0.
- frame_start_o  out  1  one-clock strobe at x_o==0 and y_o==0.
- red_i, green_i, blue_i  in  COLOR_BITS/3 each  renderer colour, valid PIPE_DELAY clocks after the coordinates it belongs to.
- hsync_o  out  1  horizontal sync to pins.
- vsync_o  out  1  vertical sync to pins.
- blank_n_o  out  1  high while the output pixel is visible.
- red_o, green_o, blue_o  out  COLOR_BITS/3 each  colour to pins.

Behaviour:
- Derived totals: H_TOTAL = H_ACTIVE+H_FP+H_SYNC+H_BP (800); V_TOTAL similarly (525).
- Counters use widths $clog2(H_TOTAL) and $clog2(V_TOTAL); the 10-bit port widths derive from these.
- Reset (async, rst_ni low):
  - h_cnt = v_cnt = 0.
  - Delay line cleared.
  - hsync_o/vsync_o at inactive level (1 when SYNC_ACTIVE_LOW).
  - blank_n_o = 0; red_o/green_o/blue_o = 0.
- Counting:
  - Each clock with enable_i high, h_cnt increments.
  - At H_TOTAL-1, h_cnt wraps to 0 and v_cnt increments.
  - When v_cnt is at V_TOTAL-1 and h_cnt wraps, v_cnt wraps to 0.
- Strobes and enable:
  - x_o, y_o, display_enable_o, line_start_o and frame_start_o are decoded directly from the counter registers, with 0 extra latency.
  - All strobes are forced low while enable_i is low.
- Sync decode (raw):
  - hsync is active for H_ACTIVE+H_FP <= h_cnt < H_ACTIVE+H_FP+H_SYNC, i.e. 656..751.
  - vsync is active for lines 490..491 across the whole line.
- Pin alignment:
  - Raw hsync, vsync and display_enable pass through a PIPE_DELAY-stage shift register, then one output register.
  - The colour input is sampled into that same output register.
  - Pin latency is PIPE_DELAY+1 clocks from the counter value.
  - When the delayed enable is low, red_o/green_o/blue_o = 0 regardless of the inputs.
- enable_i deasserted:
  - Counters clear to 0 synchronously and hold there.
  - Raw syncs go inactive and raw display enable goes to 0.
  - The delay line keeps shifting, so the pins drain to inactive within PIPE_DELAY+1 clocks.
- enable_i reasserted:
  - The raster restarts at (0,0) and frame_start_o pulses on the first enabled clock.
- Reset mid-line: all state returns to reset values immediately; no partial pulse is required to complete.
- Polarity: when SYNC_ACTIVE_LOW = 0, sync levels are inverted; everything else is unchanged.

Optional Feature:
- Macro: VGA_TEST_PATTERN_EN.
- When defined:
  - The colour input is ignored.
  - Output colour is 8 vertical bars, each H_ACTIVE/8 wide, generated from the delayed x.
  - Bar order: white, yellow, cyan, green, magenta, red, blue, black.
  - Each channel is all-ones or zero.
  - Timing and blanking are unchanged.
- When undefined: the colour input passes through as described above, and no pattern logic is synthesised.

Decomposition:
- Package vga_pkg holds:
  - Default timing constants (640x480@60).
  - Derived H_TOTAL/V_TOTAL functions.
  - Typedef rgb_t, a packed struct of red/green/blue with COLOR_BITS/3 bits each.
- Sub-module vga_delay_line: a parameterised WIDTH x DEPTH shift register with async active-low reset.
  - Used for the {hsync, vsync, de} delay and, when the pattern is enabled, for the x delay.

Test Plan:
- Reset checks:
  - Hold rst_ni low for 5 clocks → hsync_o = vsync_o = 1, blank_n_o = 0, colour = 0, x_o = y_o = 0.
  - Release with enable_i = 1 → frame_start_o = 1 on the first clock.
- Line timing:
  - Run one line → line_start_o period is 800 clocks.
  - hsync_o low for exactly 96 clocks, starting 656+PIPE_DELAY+1 = 659 clocks after line_start_o.
- Frame timing:
  - Run one frame → frame_start_o period is 420000 clocks.
  - vsync_o low during lines 490..491 only.
  - blank_n_o high for exactly 640 clocks on each of lines 0..479.
- Colour alignment: drive red_i = x_o[7:0] delayed by PIPE_DELAY → at each blank_n_o-high clock, red_o equals the x of that pixel; red_o = 0 whenever blank_n_o is low.
- Enable drop:
  - Drop enable_i at x = 300, y = 100 for 10 clocks → x_o = y_o = 0 and strobes low while low; pins inactive within 3 clocks.
  - On re-enable, frame_start_o pulses and the raster restarts at (0,0).
- Reset mid-line: assert rst_ni at x = 700 (inside hsync) → hsync_o goes high asynchronously; the counters restart cleanly from (0,0).
